// File: rtl/imm_field_encoder.sv
// Packs a signed immediate into the EXT1_* instruction field of a base word; IMM_ENC_SAT_EN clamps out-of-range values instead of truncating.
// Latency: 2 cycles (S1 range check/truncate, S2 merge), 1 beat/cycle throughput.
// Backpressure: holds up to 2 beats; in_ready drops combinationally when both stages are full and out_ready is low.
module imm_field_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [31:0]      in_base,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_ovf,
  output logic             out_bad_op,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [3:0] EXT1_0  = 4'd0;
  localparam logic [3:0] EXT1_12 = 4'd1;
  localparam logic [3:0] EXT1_16 = 4'd2;
  localparam logic [3:0] EXT1_20 = 4'd3;
  localparam logic [3:0] EXT1_28 = 4'd4;

  logic        s1_v;
  logic [3:0]  s1_op;
  logic [31:0] s1_base;
  logic [31:0] s1_mask;
  logic [19:0] s1_imm;
  logic        s1_ovf;
  logic        s1_bad;
  logic        s2_v;
  logic        s2_load;

  logic [31:0]        c_mask;
  logic [4:0]         c_w;
  logic               c_bad;
  logic               c_ovf;
  logic [19:0]        c_imm;
  logic signed [31:0] c_hi;
  logic [31:0]        placed;

  assign s2_load   = !s2_v || out_ready;
  assign in_ready  = !s1_v || s2_load;
  assign out_valid = s2_v;

  // Field mask/width per op; an immediate fits iff everything above the field's sign bit is a sign copy.
  always_comb begin
    c_mask = '0;
    c_w    = 5'd0;
    c_bad  = 1'b0;
    case (in_op)
      EXT1_12: begin c_mask = 32'h03FF_C000; c_w = 5'd12; end
      EXT1_16: begin c_mask = 32'h03FF_FC00; c_w = 5'd16; end
      EXT1_20: begin c_mask = 32'h01FF_FFE0; c_w = 5'd20; end
      EXT1_28: begin c_mask = 32'h00FF_FC1F; c_w = 5'd19; end
      EXT1_0:  ;
      default: c_bad = 1'b1;
    endcase
    c_hi  = $signed(in_imm) >>> (c_w - 5'd1);
    c_imm = in_imm[19:0] & ((20'd1 << c_w) - 20'd1);
    c_ovf = 1'b0;
    if (in_op == EXT1_0) begin
      c_ovf = (in_imm != 32'd0);
    end else if (!c_bad) begin
      c_ovf = (c_hi != 32'sd0) && (c_hi != -32'sd1);
`ifdef IMM_ENC_SAT_EN
      if (c_ovf) begin
        c_imm = in_imm[31] ? (20'd1 << (c_w - 5'd1))
                           : ((20'd1 << (c_w - 5'd1)) - 20'd1);
      end
`endif
    end
  end

  always_comb begin
    placed = '0;
    case (s1_op)
      EXT1_12: placed = {6'b0, s1_imm[11:0], 14'b0};
      EXT1_16: placed = {6'b0, s1_imm[15:0], 10'b0};
      EXT1_20: placed = {7'b0, s1_imm[19:0], 5'b0};
      EXT1_28: placed = {8'b0, s1_imm[18:5], 5'b0, s1_imm[4:0]};
      default: placed = '0;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      s1_v       <= 1'b0;
      s1_op      <= '0;
      s1_base    <= '0;
      s1_mask    <= '0;
      s1_imm     <= '0;
      s1_ovf     <= 1'b0;
      s1_bad     <= 1'b0;
      s2_v       <= 1'b0;
      out_inst   <= '0;
      out_ovf    <= 1'b0;
      out_bad_op <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (in_ready) s1_v <= in_valid;
      if (in_valid && in_ready) begin
        s1_op   <= in_op;
        s1_base <= in_base;
        s1_mask <= c_mask;
        s1_imm  <= c_imm;
        s1_ovf  <= c_ovf;
        s1_bad  <= c_bad;
      end
      if (s2_load) s2_v <= s1_v;
      if (s2_load && s1_v) begin
        out_inst   <= (s1_base & ~s1_mask) | placed;
        out_ovf    <= s1_ovf;
        out_bad_op <= s1_bad;
      end
      // Saturating: stops at all-ones.
      if (out_valid && out_ready && (out_ovf || out_bad_op) && !(&err_cnt))
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_field_encoder.sv
// Randomized and directed bench for imm_field_encoder against a field-map reference model and scoreboard.
module tb_imm_field_encoder;

  localparam logic [3:0] EXT1_0  = 4'd0;
  localparam logic [3:0] EXT1_12 = 4'd1;
  localparam logic [3:0] EXT1_16 = 4'd2;
  localparam logic [3:0] EXT1_20 = 4'd3;
  localparam logic [3:0] EXT1_28 = 4'd4;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  in_op = '0;
  logic [31:0] in_base = '0;
  logic [31:0] in_imm = '0;

  logic        in_ready, out_valid, out_ovf, out_bad_op;
  logic [31:0] out_inst;
  logic [15:0] err_cnt;
  logic        in_ready2, out_valid2, out_ovf2, out_bad_op2;
  logic [31:0] out_inst2;
  logic [1:0]  err_cnt2;

  imm_field_encoder #(.CNT_W(16)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_base(in_base), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_ovf(out_ovf),
    .out_bad_op(out_bad_op), .err_cnt(err_cnt));

  imm_field_encoder #(.CNT_W(2)) dut2 (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_op(in_op), .in_base(in_base), .in_imm(in_imm), .out_valid(out_valid2),
    .out_ready(out_ready), .out_inst(out_inst2), .out_ovf(out_ovf2),
    .out_bad_op(out_bad_op2), .err_cnt(err_cnt2));

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        ovf;
    logic        bad;
    int          t;
  } beat_t;

  beat_t q[$];
  int checks = 0;
  int fails = 0;
  int ecnt = 0;
  int cyc = 0;
  logic stall_seen = 1'b0;

  function automatic int fwidth(input logic [3:0] op);
    case (op)
      EXT1_12: return 12;
      EXT1_16: return 16;
      EXT1_20: return 20;
      EXT1_28: return 19;
      default: return 0;
    endcase
  endfunction

  // Instruction bit that holds field bit i.
  function automatic int fpos(input logic [3:0] op, input int i);
    case (op)
      EXT1_12: return 14 + i;
      EXT1_16: return 10 + i;
      EXT1_20: return 5 + i;
      EXT1_28: return (i < 5) ? i : i + 5;
      default: return i;
    endcase
  endfunction

  function automatic beat_t model(input logic [3:0] op, input logic [31:0] base, input logic [31:0] imm);
    beat_t r;
    int w;
    longint v, lo, hi, fv;
    r.op = op; r.imm = imm; r.inst = base; r.ovf = 1'b0; r.bad = 1'b0; r.t = 0;
    w = fwidth(op);
    if (op == EXT1_0) r.ovf = (imm != 0);
    else if (w == 0) r.bad = 1'b1;
    else begin
      v  = longint'($signed(imm));
      lo = -(longint'(1) << (w - 1));
      hi = (longint'(1) << (w - 1)) - 1;
      r.ovf = (v < lo) || (v > hi);
      fv = v;
`ifdef IMM_ENC_SAT_EN
      if (v < lo) fv = lo;
      if (v > hi) fv = hi;
`endif
      for (int i = 0; i < w; i++) r.inst[fpos(op, i)] = fv[i];
    end
    return r;
  endfunction

  function automatic logic [31:0] sext1(input logic [3:0] op, input logic [31:0] inst);
    int w;
    longint v;
    w = fwidth(op);
    v = 0;
    if (w == 0) return 32'd0;
    for (int i = 0; i < w; i++) v[i] = inst[fpos(op, i)];
    if (v[w-1]) v = v - (longint'(1) << w);
    return v[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check/score, then advance to the next negedge.
  task automatic cycle(input logic v, input logic [3:0] op, input logic [31:0] b,
                       input logic [31:0] imm, input logic ordy, output logic acc);
    beat_t e;
    in_valid = v; in_op = op; in_base = b; in_imm = imm; out_ready = ordy;
    #1;
    chk("out_valid", out_valid, (q.size() > 0 && cyc >= q[0].t));
    chk("in_ready", in_ready, !(q.size() == 2 && !ordy));
    if (q.size() == 2 && !ordy) stall_seen = 1'b1;
    if (out_valid && ordy && q.size() > 0) begin
      e = q.pop_front();
      chk("inst", out_inst, e.inst);
      chk("ovf", out_ovf, e.ovf);
      chk("bad_op", out_bad_op, e.bad);
      chk("err_cnt", err_cnt, ecnt);
      chk("err_cnt_w2", err_cnt2, (ecnt > 3) ? 3 : ecnt);
      if (!e.ovf && !e.bad && e.op != EXT1_0) chk("roundtrip", sext1(e.op, out_inst), e.imm);
      if ((e.ovf || e.bad) && ecnt < 65535) ecnt++;
    end
    acc = v && in_ready;
    if (acc) begin
      e = model(op, b, imm);
      e.t = cyc + 2;
      q.push_back(e);
    end
    cyc++;
    @(posedge cpu_clk);
    @(negedge cpu_clk);
  endtask

  task automatic do_reset();
    cpu_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rst = 1'b0; out_ready = 1'b0;
    q.delete(); ecnt = 0; cyc++;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_bad_op", out_bad_op, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err_cnt_w2", err_cnt2, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  task automatic drain();
    logic acc;
    int g;
    g = 0;
    while (q.size() > 0 && g < 50) begin
      cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, acc);
      g++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  function automatic logic [31:0] rand_fit(input int w);
    logic signed [31:0] sv;
    sv = $urandom;
    sv = sv << (32 - w);
    sv = sv >>> (32 - w);
    return sv;
  endfunction

  logic        acc;
  logic        v;
  logic        ordy;
  logic [3:0]  op;
  logic [31:0] b, imm;
  int          sent, guard;

  initial begin
    do_reset();

    // Directed boundary beats with no back-pressure.
    cycle(1'b1, EXT1_12, 32'hFFFF_FFFF, 32'hFFFF_F800, 1'b1, acc);
    cycle(1'b1, EXT1_12, 32'h0000_0000, 32'h0000_07FF, 1'b1, acc);
    cycle(1'b1, EXT1_12, 32'hA5A5_A5A5, 32'h0000_0800, 1'b1, acc);
    cycle(1'b1, EXT1_28, 32'h0000_0000, 32'h0003_FFFF, 1'b1, acc);
    cycle(1'b1, EXT1_28, 32'h0000_0000, 32'h0004_0000, 1'b1, acc);
    cycle(1'b1, EXT1_28, 32'hFFFF_FFFF, 32'hFFFC_0000, 1'b1, acc);
    cycle(1'b1, EXT1_28, 32'h0000_0000, 32'hFFFB_FFFF, 1'b1, acc);
    cycle(1'b1, EXT1_0,  32'hDEAD_BEEF, 32'h0000_0000, 1'b1, acc);
    cycle(1'b1, EXT1_0,  32'hDEAD_BEEF, 32'h0000_0001, 1'b1, acc);
    cycle(1'b1, EXT1_20, 32'h1234_5678, 32'hFFF8_0000, 1'b1, acc);
    cycle(1'b1, 4'hF,    32'h1234_5678, 32'h0000_0003, 1'b1, acc);
    drain();

    // Bad op alone moves err_cnt 0 -> 1.
    do_reset();
    cycle(1'b1, 4'hF, 32'h1234_5678, 32'h0000_0000, 1'b1, acc);
    drain();
    chk("badop_err_cnt", err_cnt, 1);

    // Eight in-range EXT1_16/EXT1_20 beats with out_ready toggling.
    stall_seen = 1'b0;
    sent = 0; guard = 0;
    op = ($urandom_range(0, 1) != 0) ? EXT1_16 : EXT1_20;
    b = $urandom; imm = rand_fit(fwidth(op));
    while (sent < 8 && guard < 200) begin
      cycle(1'b1, op, b, imm, guard[0], acc);
      guard++;
      if (acc) begin
        sent++;
        op = ($urandom_range(0, 1) != 0) ? EXT1_16 : EXT1_20;
        b = $urandom; imm = rand_fit(fwidth(op));
      end
    end
    chk("stream_sent", sent, 8);
    drain();
    chk("stream_full_seen", stall_seen, 1);

    // Random ops, valid and ready; beats are held until accepted.
    sent = 0; guard = 0;
    v = 1'b0;
    while (sent < 60 && guard < 2000) begin
      if (!v) begin
        v = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 5))
          0: op = EXT1_0;
          1: op = EXT1_12;
          2: op = EXT1_16;
          3: op = EXT1_20;
          4: op = EXT1_28;
          default: op = 4'($urandom_range(5, 15));
        endcase
        b = $urandom;
        imm = ($urandom_range(0, 1) != 0 && fwidth(op) > 0) ? rand_fit(fwidth(op)) : $urandom;
        if (op == EXT1_0 && $urandom_range(0, 1) != 0) imm = 32'd0;
      end
      ordy = ($urandom_range(0, 3) != 0);
      cycle(v, op, b, imm, ordy, acc);
      guard++;
      if (acc) begin sent++; v = 1'b0; end
      else if (!v) v = 1'b0;
    end
    chk("random_sent", sent, 60);
    drain();

    // Reset with two error beats in flight discards them uncounted.
    do_reset();
    cycle(1'b1, 4'hE, 32'h0, 32'h0, 1'b1, acc);
    drain();
    cycle(1'b1, EXT1_0, 32'h1111_1111, 32'h5, 1'b0, acc);
    cycle(1'b1, EXT1_0, 32'h2222_2222, 32'h6, 1'b0, acc);
    chk("inflight_count", q.size(), 2);
    cycle(1'b1, EXT1_0, 32'h3333_3333, 32'h7, 1'b0, acc);
    chk("full_blocks_accept", acc, 0);
    do_reset();
    drain();

    // Narrow counter: five overflow beats saturate at 3.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, EXT1_12, $urandom, 32'h0000_1000, 1'b1, acc);
    drain();
    chk("sat_err_cnt_w2", err_cnt2, 3);
    chk("sat_err_cnt_w16", err_cnt, 5);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
